demux_rr_scheduler: RTL and testbench

Round-robin scheduler that drives the select lines of the 1-to-4 demultiplexer and sequences a single valid/ready input stream across four destinations. It buffers one item and holds each destination for a burst of `BURST` items before rotating to the next enabled destination. It skips destinations masked off in `en_mask`. It sits between the upstream producer and the demux, owning `{s1,s0}` and the per-destination handshakes.

---
 rtl/demux_sched_pkg.sv | 32 +++
 rtl/rr_next_pick.sv | 15 +
 rtl/demux_rr_scheduler.sv | 109 ++++++++++
 tb/tb_demux_rr_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared constants, FSM state encoding and the round-robin search helper
// for the demux round-robin scheduler.
package demux_sched_pkg;

  localparam int NUM_DEST = 4;
  localparam int SEL_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // First enabled destination searching sel+1, sel+2, sel+3, sel (mod 4).
  // The loop runs from the lowest-priority candidate upward so that the
  // last hit written (sel+1) wins. With an empty mask, sel is returned.
  function automatic logic [SEL_W-1:0] next_enabled(
    input logic [SEL_W-1:0]    sel,
    input logic [NUM_DEST-1:0] mask
  );
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] cand;
    pick = sel;
    for (int k = NUM_DEST; k >= 1; k--) begin
      cand = sel + SEL_W'(k);
      if (mask[cand]) begin
        pick = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Combinational wrap-around priority search: picks the next enabled
// destination after the current select.
module rr_next_pick
  import demux_sched_pkg::*;
(
  input  logic [SEL_W-1:0]    sel,
  input  logic [NUM_DEST-1:0] en_mask,
  output logic [SEL_W-1:0]    next_sel,
  output logic                any_en
);

  assign next_sel = next_enabled(sel, en_mask);
  assign any_en   = |en_mask;

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler for a 1-to-4 demux: one-entry buffer, per-destination
// burst counting, registered select and rotation over enabled destinations.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_DEST-1:0] en_mask,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                s0,
  output logic                s1,
  output logic [DATA_W-1:0]   f_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic                busy
);

  state_t             state_reg;
  state_t             state_next;
  logic [SEL_W-1:0]   sel_reg;
  logic               buf_valid_reg;
  logic [DATA_W-1:0]  f_data_reg;
  logic [7:0]         burst_cnt_reg;

  logic [SEL_W-1:0]   pick_sel;
  logic               any_en;
  logic               in_fire;
  logic               out_fire;
  logic               burst_last;
  logic               sel_disabled_idle;

  rr_next_pick u_pick (
    .sel      (sel_reg),
    .en_mask  (en_mask),
    .next_sel (pick_sel),
    .any_en   (any_en)
  );

  assign out_fire   = buf_valid_reg & out_ready[sel_reg];
  // Reset gating keeps in_ready low for the whole reset cycle even when the
  // state register still holds RUN from before reset.
  assign in_ready   = ~rst & (state_reg == ST_RUN) & any_en
                      & (~buf_valid_reg | out_fire);
  assign in_fire    = in_valid & in_ready;
  assign burst_last = (burst_cnt_reg == 8'(BURST - 1));
  // Current destination was switched off with nothing committed to it.
  assign sel_disabled_idle = ~buf_valid_reg & ~en_mask[sel_reg] & any_en;

  assign s0     = sel_reg[0];
  assign s1     = sel_reg[1];
  assign f_data = f_data_reg;
  assign busy   = buf_valid_reg | (burst_cnt_reg != 8'd0);

  // One-hot valid towards the destination currently selected.
  generate
    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_out_valid
      assign out_valid[gi] = buf_valid_reg & (sel_reg == SEL_W'(gi));
    end
  endgenerate

  // Next-state logic: run while any destination is enabled, and drain the
  // committed item before dropping back to idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_en) state_next = ST_RUN;
      ST_RUN:  if (!any_en && !buf_valid_reg) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, buffer, burst counter and select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= '0;
      buf_valid_reg <= 1'b0;
      f_data_reg    <= '0;
      burst_cnt_reg <= 8'd0;
    end else begin
      state_reg <= state_next;

      if (in_fire) begin
        buf_valid_reg <= 1'b1;
        f_data_reg    <= in_data;
      end else if (out_fire) begin
        buf_valid_reg <= 1'b0;
      end

      // Select only moves at a burst end or while the buffer is empty, so a
      // buffered item always leaves under the select it was presented at.
      if (out_fire && burst_last) begin
        burst_cnt_reg <= 8'd0;
        if (any_en) sel_reg <= pick_sel;
      end else if (out_fire) begin
        burst_cnt_reg <= burst_cnt_reg + 8'd1;
      end else if (sel_disabled_idle) begin
        burst_cnt_reg <= 8'd0;
        sel_reg       <= pick_sel;
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench for demux_rr_scheduler: the stimulus side queues the
// expected {destination, data} of every item it offers; a monitor pops and
// compares on every delivery observed at the demux side.
module tb_demux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en_mask = 4'b0000;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       s0, s1;
  logic [7:0] f_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'b1111;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         stalls = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  logic [3:0] mon_oh;

  demux_rr_scheduler #(.DATA_W(8), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .s0        (s0),
    .s1        (s1),
    .f_data    (f_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every delivery (valid & ready on the selected line) pops one
  // expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid != 4'b0000) begin
      mon_oh = 4'b0001 << {s1, s0};
      check("onehot", {28'd0, out_valid}, {28'd0, mon_oh});
      if ((out_valid & out_ready) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_item: got dest %0d data 0x%02h, expected none", {s1, s0}, f_data);
        end else begin
          mon_e = exp_q.pop_front();
          $display("deliver dest=%0d data=0x%02h (expected dest=%0d data=0x%02h)",
                   {s1, s0}, f_data, mon_e[9:8], mon_e[7:0]);
          check("dest", {30'd0, s1, s0}, {30'd0, mon_e[9:8]});
          check("data", {24'd0, f_data}, {24'd0, mon_e[7:0]});
        end
      end
    end
  end

  // Offer one item (called just after a rising edge) and wait until accepted.
  task automatic send(input logic [7:0] d, input logic [1:0] dest);
    bit done;
    int t;
    done = 1'b0;
    t = 0;
    exp_q.push_back({dest, d});
    in_valid = 1'b1;
    in_data  = d;
    while (!done && t < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (!done) stalls++;
      t++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: got no in_ready, expected accept of 0x%02h", d);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset(input logic [3:0] mask);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    en_mask   = mask;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", {28'd0, out_valid}, 0);
    check("rst_sel", {30'd0, s1, s0}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_f_data", {24'd0, f_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Mask held at zero, then a single destination (c).
    do_reset(4'b0000);
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 0);
      check("idle_sel", {30'd0, s1, s0}, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    en_mask  = 4'b0100;
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 2'd2);
    in_valid = 1'b0;
    drain();
    check("single_dest_sel", {30'd0, s1, s0}, 2);
    check("single_dest_busy", {31'd0, busy}, 0);

    // All destinations enabled, 16 back-to-back items.
    do_reset(4'b1111);
    send(8'h00, 2'd0);
    stalls = 0;
    for (int i = 1; i < 16; i++) send(8'(i), 2'(i / 4));
    in_valid = 1'b0;
    check("stream_stalls", stalls, 0);
    drain();

    // Only b and d enabled.
    do_reset(4'b1010);
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), (i < 4) ? 2'd1 : 2'd3);
    in_valid = 1'b0;
    drain();

    // Back-pressure on a with an item buffered.
    do_reset(4'b1111);
    out_ready = 4'b1110;
    send(8'hA5, 2'd0);
    in_valid = 1'b1;
    in_data  = 8'hA6;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", {28'd0, out_valid}, 32'h1);
      check("stall_data", {24'd0, f_data}, 32'hA5);
      check("stall_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 4'b1111;
    send(8'hA6, 2'd0);
    in_valid = 1'b0;
    drain();

    // Disable a while 0x33 is committed to it.
    do_reset(4'b1111);
    out_ready = 4'b1110;
    send(8'h33, 2'd0);
    in_valid = 1'b0;
    en_mask  = 4'b1110;
    @(negedge clk);
    check("commit_valid", {28'd0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    check("commit_sel_hold", {30'd0, s1, s0}, 0);
    check("commit_busy_cnt", {31'd0, busy}, 1);
    @(posedge clk);
    #1;
    check("disable_rotate_sel", {30'd0, s1, s0}, 1);
    check("disable_cnt_clear", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 2'd1);
    in_valid = 1'b0;
    drain();

    // Reset two items into a burst.
    do_reset(4'b1111);
    send(8'h60, 2'd0);
    send(8'h61, 2'd0);
    in_valid = 1'b0;
    drain();
    check("busy_partial", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {28'd0, out_valid}, 0);
    check("midrst_sel", {30'd0, s1, s0}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(8'h70 + 8'(i), 2'd0);
    in_valid = 1'b0;
    drain();

    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
